// File: rtl/resp_misr_checker_pkg.sv
// Shared types and the MISR step function for the response signature checker.
// Functions take generous-width vectors; callers pass their real width and polynomial.
package resp_chk_pkg;

  localparam int unsigned MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    CHECK   = 2'd2,
    DONE    = 2'd3
  } state_e;

  // One MISR step: shift left, fold POLY in when the outgoing bit is set, xor the response in.
  function automatic logic [MAX_W-1:0] misr_next(
    input logic [MAX_W-1:0] s,
    input logic [MAX_W-1:0] d,
    input logic [MAX_W-1:0] poly,
    input int unsigned      sig_w
  );
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] top_bit;
    logic [MAX_W-1:0] nxt;
    mask    = {MAX_W{1'b1}} >> (MAX_W - sig_w);
    top_bit = {{(MAX_W-1){1'b0}}, 1'b1} << (sig_w - 1);
    nxt     = (s << 1) & mask;
    if ((s & top_bit) != {MAX_W{1'b0}}) begin
      nxt = nxt ^ poly;
    end else begin
      nxt = nxt;
    end
    return (nxt ^ d) & mask;
  endfunction

endpackage

// File: rtl/resp_misr_checker_if.sv
// Handshake/result bundle between a response source and resp_misr_checker.
// The timeout signal exists only when RESP_TIMEOUT_EN is defined.
interface resp_misr_checker_if #(
  parameter int unsigned DATA_W = 2,
  parameter int unsigned SIG_W  = 16,
  parameter int unsigned CNT_W  = 5
);
  logic              start;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic [SIG_W-1:0]  golden_sig;
  logic              busy;
  logic              done;
  logic              pass;
  logic [SIG_W-1:0]  signature;
  logic [CNT_W-1:0]  resp_count;
`ifdef RESP_TIMEOUT_EN
  logic              timeout;
`endif

  modport master (
    output start, resp_valid, resp_data, golden_sig,
`ifdef RESP_TIMEOUT_EN
    input  timeout,
`endif
    input  busy, done, pass, signature, resp_count
  );

  modport slave (
    input  start, resp_valid, resp_data, golden_sig,
`ifdef RESP_TIMEOUT_EN
    output timeout,
`endif
    output busy, done, pass, signature, resp_count
  );
endinterface

// File: rtl/resp_misr_checker_misr.sv
// Signature register: load forces SEED, step absorbs one response; load has priority.
module resp_misr
  import resp_chk_pkg::*;
#(
  parameter int unsigned       DATA_W = 2,
  parameter int unsigned       SIG_W  = 16,
  parameter logic [SIG_W-1:0]  POLY   = 16'h1021,
  parameter logic [SIG_W-1:0]  SEED   = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] data,
  output logic [SIG_W-1:0]  sig
);

  logic [SIG_W-1:0] sig_d;
  logic [SIG_W-1:0] sig_q;

  always_comb begin
    sig_d = sig_q;
    if (load) begin
      sig_d = SEED;
    end else if (step) begin
      sig_d = SIG_W'(misr_next(MAX_W'(sig_q), MAX_W'(data), MAX_W'(POLY), SIG_W));
    end else begin
      sig_d = sig_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/resp_misr_checker.sv
// Response MISR checker: FSM, response counter, golden compare and optional watchdog.
// Define RESP_TIMEOUT_EN to add the CAPTURE-idle watchdog and the timeout output.
module resp_misr_checker
  import resp_chk_pkg::*;
#(
  parameter int unsigned       DATA_W      = 2,
  parameter int unsigned       N_PATTERNS  = 16,
  parameter int unsigned       SIG_W       = 16,
  parameter logic [SIG_W-1:0]  POLY        = 16'h1021,
  parameter logic [SIG_W-1:0]  SEED        = 16'hFFFF,
  parameter int unsigned       TIMEOUT_CYC = 64
) (
  input logic                clk,
  input logic                rst,
  resp_misr_checker_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(N_PATTERNS + 1);

  state_e           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             busy_d, busy_q;
  logic             done_d, done_q;
  logic             pass_d, pass_q;
  logic             misr_load;
  logic             misr_step;
  logic [SIG_W-1:0] sig_s;
`ifdef RESP_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0]  wd_d, wd_q;
  logic             timeout_d, timeout_q;
`endif

  resp_misr #(
    .DATA_W (DATA_W),
    .SIG_W  (SIG_W),
    .POLY   (POLY),
    .SEED   (SEED)
  ) u_misr (
    .clk  (clk),
    .rst  (rst),
    .load (misr_load),
    .step (misr_step),
    .data (bus.resp_data),
    .sig  (sig_s)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    pass_d    = pass_q;
    misr_load = 1'b0;
    misr_step = 1'b0;
`ifdef RESP_TIMEOUT_EN
    wd_d      = wd_q;
    timeout_d = timeout_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        // start outranks a coincident resp_valid: the run begins clean from SEED
        if (bus.start) begin
          state_d   = CAPTURE;
          cnt_d     = {CNT_W{1'b0}};
          done_d    = 1'b0;
          pass_d    = 1'b0;
          misr_load = 1'b1;
`ifdef RESP_TIMEOUT_EN
          wd_d      = {WD_W{1'b0}};
          timeout_d = 1'b0;
`endif
        end else begin
          state_d = state_q;
        end
      end
      CAPTURE: begin
        if (bus.resp_valid) begin
          misr_step = 1'b1;
          cnt_d     = cnt_q + CNT_W'(1);
`ifdef RESP_TIMEOUT_EN
          wd_d      = {WD_W{1'b0}};
`endif
          if (cnt_q == CNT_W'(N_PATTERNS - 1)) begin
            state_d = CHECK;
          end else begin
            state_d = CAPTURE;
          end
        end else begin
`ifdef RESP_TIMEOUT_EN
          wd_d = wd_q + WD_W'(1);
          if (wd_d == WD_W'(TIMEOUT_CYC)) begin
            state_d   = DONE;
            done_d    = 1'b1;
            pass_d    = 1'b0;
            timeout_d = 1'b1;
          end else begin
            state_d = CAPTURE;
          end
`else
          state_d = CAPTURE;
`endif
        end
      end
      CHECK: begin
        pass_d  = (sig_s == bus.golden_sig);
        done_d  = 1'b1;
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == CAPTURE) || (state_d == CHECK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
`ifdef RESP_TIMEOUT_EN
      wd_q      <= {WD_W{1'b0}};
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
`ifdef RESP_TIMEOUT_EN
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.signature  = sig_s;
  assign bus.resp_count = cnt_q;
`ifdef RESP_TIMEOUT_EN
  assign bus.timeout    = timeout_q;
`endif

endmodule

// File: tb/tb_resp_misr_checker.sv
// Directed bench for resp_misr_checker: a default 16-pattern instance and a 1-pattern, SEED=1 instance.
// Golden signatures are hand-computed for POLY 16'h1021.
module tb_resp_misr_checker;

  localparam logic [15:0] GOLD_AND = 16'h186C;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  resp_misr_checker_if #(.DATA_W(2), .SIG_W(16), .CNT_W(5)) bus  ();
  resp_misr_checker_if #(.DATA_W(2), .SIG_W(16), .CNT_W(1)) bus1 ();

  resp_misr_checker #(.DATA_W(2), .N_PATTERNS(16), .SIG_W(16), .POLY(16'h1021),
                      .SEED(16'hFFFF), .TIMEOUT_CYC(64))
    u_dut (.clk(clk), .rst(rst), .bus(bus));

  resp_misr_checker #(.DATA_W(2), .N_PATTERNS(1), .SIG_W(16), .POLY(16'h1021),
                      .SEED(16'h0001), .TIMEOUT_CYC(64))
    u_one (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] and_resp(input int i);
    logic [3:0] v;
    v = 4'(i);
    return v[1:0] & v[3:2];
  endfunction

  task automatic start_run();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Feeds AND responses lo..hi with a one-cycle gap before every third pattern.
  task automatic feed(input int lo, input int hi, input bit flip7);
    for (int i = lo; i <= hi; i++) begin
      if (i % 3 == 2) begin
        bus.resp_valid = 1'b0;
        tick();
      end
      bus.resp_valid = 1'b1;
      bus.resp_data  = and_resp(i) ^ ((flip7 && i == 7) ? 2'b01 : 2'b00);
      tick();
    end
    bus.resp_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 8 && !ok; k++) begin
      if (bus.done === 1'b1) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_cmp++; if (bus.signature !== 16'hFFFF) begin n_err++; $display("FAIL rst_sig: got %h want ffff", bus.signature); end
    n_cmp++; if ({bus.busy, bus.done, bus.pass} !== 3'b000) begin n_err++; $display("FAIL rst_flags: got %b want 000", {bus.busy, bus.done, bus.pass}); end
    n_cmp++; if (bus1.signature !== 16'h0001) begin n_err++; $display("FAIL rst_sig_one: got %h want 0001", bus1.signature); end
    rst = 1'b0;
    tick();
    start_run();
    feed(0, 6, 1'b0);
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL midrun_busy: got %b want 1", bus.busy); end
    rst = 1'b1;
    #1;
    n_cmp++; if ({bus.busy, bus.done, bus.pass, bus.resp_count} !== 8'h00) begin n_err++; $display("FAIL async_rst: got %h want 00", {bus.busy, bus.done, bus.pass, bus.resp_count}); end
    tick();
    n_cmp++; if (bus.signature !== 16'hFFFF) begin n_err++; $display("FAIL rst_sig_mid: got %h want ffff", bus.signature); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_beat();
    logic [1:0]  dat [3] = '{2'b00, 2'b11, 2'b00};
    logic [15:0] sig [3] = '{16'h0002, 16'h0001, 16'h0002};
    logic [15:0] gld [3] = '{16'h0002, 16'h0001, 16'h0000};
    for (int r = 0; r < 3; r++) begin
      bus1.golden_sig = gld[r];
      bus1.start = 1'b1;
      tick();
      bus1.start = 1'b0;
      bus1.resp_valid = 1'b1;
      bus1.resp_data  = dat[r];
      tick();
      bus1.resp_valid = 1'b0;
      n_cmp++; if (bus1.signature !== sig[r]) begin n_err++; $display("FAIL one_sig[%0d]: got %h want %h", r, bus1.signature, sig[r]); end
      n_cmp++; if (bus1.done !== 1'b0) begin n_err++; $display("FAIL one_done_early[%0d]: got %b want 0", r, bus1.done); end
      tick();
      n_cmp++; if (bus1.done !== 1'b1) begin n_err++; $display("FAIL one_done_lat[%0d]: got %b want 1", r, bus1.done); end
      n_cmp++; if (bus1.pass !== (r != 2)) begin n_err++; $display("FAIL one_pass[%0d]: got %b want %b", r, bus1.pass, r != 2); end
    end
  endtask

  task automatic test_exhaustive();
    bit ok;
    bus.golden_sig = GOLD_AND;
    start_run();
    feed(0, 15, 1'b0);
    wait_done(ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL exh_done: got %b want 1", ok); end
    n_cmp++; if (bus.signature !== GOLD_AND) begin n_err++; $display("FAIL exh_sig: got %h want %h", bus.signature, GOLD_AND); end
    n_cmp++; if (bus.resp_count !== 5'd16) begin n_err++; $display("FAIL exh_count: got %0d want 16", bus.resp_count); end
    n_cmp++; if (bus.pass !== 1'b1) begin n_err++; $display("FAIL exh_pass: got %b want 1", bus.pass); end
  endtask

  task automatic test_flip();
    bit ok;
    start_run();
    feed(0, 15, 1'b1);
    wait_done(ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL flip_done: got %b want 1", ok); end
    n_cmp++; if (bus.pass !== 1'b0) begin n_err++; $display("FAIL flip_pass: got %b want 0", bus.pass); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    start_run();
    n_cmp++; if ({bus.done, bus.pass, bus.busy} !== 3'b001) begin n_err++; $display("FAIL b2b_flags: got %b want 001", {bus.done, bus.pass, bus.busy}); end
    n_cmp++; if (bus.signature !== 16'hFFFF) begin n_err++; $display("FAIL b2b_seed: got %h want ffff", bus.signature); end
    feed(0, 15, 1'b0);
    wait_done(ok);
    n_cmp++; if ({ok, bus.pass} !== 2'b11) begin n_err++; $display("FAIL b2b_pass: got %b want 11", {ok, bus.pass}); end
    n_cmp++; if (bus.signature !== GOLD_AND) begin n_err++; $display("FAIL b2b_sig: got %h want %h", bus.signature, GOLD_AND); end
  endtask

  task automatic test_ignored();
    bit ok;
    start_run();
    feed(0, 4, 1'b0);
    start_run();
    n_cmp++; if ({bus.busy, bus.resp_count} !== {1'b1, 5'd5}) begin n_err++; $display("FAIL ign_start: got %b/%0d want 1/5", bus.busy, bus.resp_count); end
    feed(5, 15, 1'b0);
    wait_done(ok);
    n_cmp++; if ({ok, bus.pass} !== 2'b11) begin n_err++; $display("FAIL ign_pass: got %b want 11", {ok, bus.pass}); end
    bus.resp_valid = 1'b1;
    bus.resp_data  = 2'b11;
    tick(); tick(); tick();
    bus.resp_valid = 1'b0;
    n_cmp++; if (bus.signature !== GOLD_AND) begin n_err++; $display("FAIL ign_done_sig: got %h want %h", bus.signature, GOLD_AND); end
    n_cmp++; if ({bus.done, bus.resp_count} !== {1'b1, 5'd16}) begin n_err++; $display("FAIL ign_done_cnt: got %b/%0d want 1/16", bus.done, bus.resp_count); end
  endtask

`ifdef RESP_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    start_run();
    repeat (63) tick();
    n_cmp++; if ({bus.timeout, bus.done, bus.busy} !== 3'b001) begin n_err++; $display("FAIL to_early: got %b want 001", {bus.timeout, bus.done, bus.busy}); end
    tick();
    n_cmp++; if ({bus.timeout, bus.done, bus.pass} !== 3'b110) begin n_err++; $display("FAIL to_fire: got %b want 110", {bus.timeout, bus.done, bus.pass}); end
    start_run();
    n_cmp++; if (bus.timeout !== 1'b0) begin n_err++; $display("FAIL to_clear: got %b want 0", bus.timeout); end
    for (int i = 0; i < 16; i++) begin
      repeat (62) tick();
      bus.resp_valid = 1'b1;
      bus.resp_data  = and_resp(i);
      tick();
      bus.resp_valid = 1'b0;
    end
    wait_done(ok);
    n_cmp++; if ({ok, bus.timeout, bus.pass} !== 3'b101) begin n_err++; $display("FAIL to_slow_run: got %b want 101", {ok, bus.timeout, bus.pass}); end
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.start = 1'b0;  bus.resp_valid = 1'b0;  bus.resp_data = 2'b00;  bus.golden_sig = 16'h0000;
    bus1.start = 1'b0; bus1.resp_valid = 1'b0; bus1.resp_data = 2'b00; bus1.golden_sig = 16'h0000;
    test_reset();
    test_single_beat();
    test_exhaustive();
    test_flip();
    test_back_to_back();
    test_ignored();
`ifdef RESP_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
